// File: rtl/tlul_rr_arbiter_if.sv
// Bundle of host-side and device-side TL-UL channel signals for the
// round-robin arbiter.
//   slave  : arbiter view (hosts' A/D-ready in, device D in, device A out)
//   master : environment view (hosts and device drive, arbiter outputs in)
interface tlul_rr_arbiter_if #(
    parameter int NumHost = 2
);
    // host side, host -> arbiter
    logic [NumHost-1:0]        h_a_valid;
    logic [NumHost-1:0][2:0]   h_a_opcode;
    logic [NumHost-1:0][31:0]  h_a_address;
    logic [NumHost-1:0][31:0]  h_a_data;
    logic [NumHost-1:0][3:0]   h_a_mask;
    logic [NumHost-1:0][7:0]   h_a_source;
    logic [NumHost-1:0]        h_d_ready;
    // host side, arbiter -> host
    logic [NumHost-1:0]        h_a_ready;
    logic [NumHost-1:0]        h_d_valid;
    logic [NumHost-1:0][2:0]   h_d_opcode;
    logic [NumHost-1:0][31:0]  h_d_data;
    logic [NumHost-1:0][7:0]   h_d_source;
    logic [NumHost-1:0]        h_d_error;
    // device side, arbiter -> device
    logic                      d_a_valid;
    logic [2:0]                d_a_opcode;
    logic [31:0]               d_a_address;
    logic [31:0]               d_a_data;
    logic [3:0]                d_a_mask;
    logic [7:0]                d_a_source;
    logic                      d_d_ready;
    // device side, device -> arbiter
    logic                      d_a_ready;
    logic                      d_d_valid;
    logic [2:0]                d_d_opcode;
    logic [31:0]               d_d_data;
    logic [7:0]                d_d_source;
    logic                      d_d_error;

    modport slave (
        input  h_a_valid, h_a_opcode, h_a_address, h_a_data,
        input  h_a_mask, h_a_source, h_d_ready,
        input  d_a_ready, d_d_valid, d_d_opcode, d_d_data,
        input  d_d_source, d_d_error,
        output h_a_ready, h_d_valid, h_d_opcode, h_d_data,
        output h_d_source, h_d_error,
        output d_a_valid, d_a_opcode, d_a_address, d_a_data,
        output d_a_mask, d_a_source, d_d_ready
    );

    modport master (
        output h_a_valid, h_a_opcode, h_a_address, h_a_data,
        output h_a_mask, h_a_source, h_d_ready,
        output d_a_ready, d_d_valid, d_d_opcode, d_d_data,
        output d_d_source, d_d_error,
        input  h_a_ready, h_d_valid, h_d_opcode, h_d_data,
        input  h_d_source, h_d_error,
        input  d_a_valid, d_a_opcode, d_a_address, d_a_data,
        input  d_a_mask, d_a_source, d_d_ready
    );
endinterface

// File: rtl/tlul_rr_arbiter.sv
// Shares one TL-UL device port among NumHost hosts: round-robin A-channel
// grant held while the device stalls, D-channel routed in order via a
// host-index FIFO.
//   clk_i, rst_ni  : clock, async active-low reset
//   tl             : host and device channels (slave view)
//   outstanding_o  : accepted-but-unanswered request count
//   unexp_rsp_o    : pulse when a response arrives with nothing outstanding
module tlul_rr_arbiter #(
    parameter int NumHost        = 2,
    parameter int MaxOutstanding = 4,
    localparam int IdxW = (NumHost > 1) ? $clog2(NumHost) : 1,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tlul_rr_arbiter_if.slave tl,
    output logic [CntW-1:0] outstanding_o,
    output logic            unexp_rsp_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [IdxW-1:0] fifo [MaxOutstanding];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    logic [IdxW-1:0] rr_last;
    logic [IdxW-1:0] lock_idx;
    logic            lock;
    logic            unexp_q;

    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] gnt;
    logic [IdxW-1:0] head;
    logic            any_req;
    logic            full;
    logic            has_head;
    logic            a_valid;
    logic            push;
    logic            pop;

    // Scan from the farthest candidate back to the nearest so the
    // first requester after rr_last is the one left standing.
    always_comb begin
        arb_idx = '0;
        for (int k = NumHost; k >= 1; k--) begin
            if (tl.h_a_valid[IdxW'((int'(rr_last) + k) % NumHost)]) begin
                arb_idx = IdxW'((int'(rr_last) + k) % NumHost);
            end
        end
    end

    assign any_req  = |tl.h_a_valid;
    assign full     = (count == CntW'(MaxOutstanding));
    assign gnt      = lock ? lock_idx : arb_idx;
    assign a_valid  = rst_ni & any_req & ~full;
    assign push     = a_valid & tl.d_a_ready;
    assign has_head = (count != '0);
    assign head     = fifo[rd_ptr];
    assign pop      = has_head & tl.d_d_valid & tl.d_d_ready;

    assign tl.d_a_valid   = a_valid;
    assign tl.d_a_opcode  = tl.h_a_opcode[gnt];
    assign tl.d_a_address = tl.h_a_address[gnt];
    assign tl.d_a_data    = tl.h_a_data[gnt];
    assign tl.d_a_mask    = tl.h_a_mask[gnt];
    assign tl.d_a_source  = tl.h_a_source[gnt];

    // With nothing outstanding the device is drained unconditionally.
    assign tl.d_d_ready = has_head ? tl.h_d_ready[head] : 1'b1;

    always_comb begin
        for (int i = 0; i < NumHost; i++) begin
            tl.h_a_ready[i]  = rst_ni & tl.d_a_ready & ~full
                             & (gnt == IdxW'(i));
            tl.h_d_valid[i]  = has_head & tl.d_d_valid
                             & (head == IdxW'(i));
            tl.h_d_opcode[i] = tl.d_d_opcode;
            tl.h_d_data[i]   = tl.d_d_data;
            tl.h_d_source[i] = tl.d_d_source;
            tl.h_d_error[i]  = tl.d_d_error;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr_last  <= IdxW'(NumHost - 1);
            lock     <= 1'b0;
            lock_idx <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= gnt;
                wr_ptr       <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
                rr_last      <= gnt;
                lock         <= 1'b0;
            end else if (a_valid) begin
                // Device stalled: freeze the grant so A stays stable.
                lock     <= 1'b1;
                lock_idx <= gnt;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
            end
            count   <= count + CntW'(push) - CntW'(pop);
            unexp_q <= ~has_head & tl.d_d_valid;
        end
    end

    assign outstanding_o = count;
    assign unexp_rsp_o   = unexp_q;
endmodule

// File: tb/tb_tlul_rr_arbiter.sv
// Randomized scoreboard bench for tlul_rr_arbiter: transaction-level host,
// device and round-robin reference model with an independent D monitor.
module tb_tlul_rr_arbiter;
    localparam int NH = 2;
    localparam int MO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  src;
    } req_t;

    typedef struct {
        int          host;
        logic [31:0] rsp;
        logic [7:0]  src;
    } exp_t;

    typedef struct {
        logic [31:0] rsp;
        logic [7:0]  src;
    } dev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outstanding;
    logic       unexp;

    always #5 clk = ~clk;

    tlul_rr_arbiter_if #(.NumHost(NH)) bus ();

    tlul_rr_arbiter #(
        .NumHost(NH),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .tl(bus),
        .outstanding_o(outstanding),
        .unexp_rsp_o(unexp)
    );

    req_t hq [NH][$];
    exp_t exp_q [$];
    dev_t dev_q [$];

    int errors = 0;
    int checks = 0;
    int seq = 0;
    int owner = -1;
    int last_win = NH - 1;
    int p_req, p_ardy, p_dvld, p_drdy;
    bit rsp_en = 1'b1;
    bit mon_en = 1'b0;
    bit d_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    // D-channel monitor: every host-side response is matched against the
    // acceptance-ordered scoreboard.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            for (int i = 0; i < NH; i++) begin
                if (bus.h_d_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        fail("d_spurious_host", i, -1);
                    end else begin
                        chk("d_route", i, exp_q[0].host);
                        if (bus.h_d_ready[i]) begin
                            chk("d_data", bus.h_d_data[i], exp_q[0].rsp);
                            chk("d_source", bus.h_d_source[i], exp_q[0].src);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        bus.h_a_valid   = '0;
        bus.h_a_opcode  = '0;
        bus.h_a_address = '0;
        bus.h_a_data    = '0;
        bus.h_a_mask    = '0;
        bus.h_a_source  = '0;
        bus.h_d_ready   = '0;
        bus.d_a_ready   = 1'b0;
        bus.d_d_valid   = 1'b0;
        bus.d_d_opcode  = 3'd1;
        bus.d_d_data    = '0;
        bus.d_d_source  = '0;
        bus.d_d_error   = 1'b0;
    endtask

    task automatic clear_model();
        for (int h = 0; h < NH; h++) hq[h].delete();
        exp_q.delete();
        dev_q.delete();
        owner    = -1;
        last_win = NH - 1;
        d_hold   = 1'b0;
    endtask

    task automatic step();
        int   cnt;
        bit   any;
        bit   exp_av;
        logic exp_dr;
        req_t r;
        @(negedge clk);
        for (int h = 0; h < NH; h++) begin
            if (hq[h].size() == 0 && roll(p_req)) begin
                r.addr = $urandom;
                r.data = $urandom;
                r.src  = 8'(h * 128 + seq % 128);
                seq++;
                hq[h].push_back(r);
            end
            bus.h_a_valid[h] = (hq[h].size() != 0);
            if (hq[h].size() != 0) begin
                bus.h_a_opcode[h]  = 3'd0;
                bus.h_a_address[h] = hq[h][0].addr;
                bus.h_a_data[h]    = hq[h][0].data;
                bus.h_a_mask[h]    = 4'hf;
                bus.h_a_source[h]  = hq[h][0].src;
            end else begin
                bus.h_a_address[h] = '0;
                bus.h_a_data[h]    = '0;
                bus.h_a_source[h]  = '0;
            end
            bus.h_d_ready[h] = roll(p_drdy);
        end
        if (!d_hold) d_hold = rsp_en && dev_q.size() != 0 && roll(p_dvld);
        bus.d_d_valid = d_hold;
        if (d_hold) begin
            bus.d_d_data   = dev_q[0].rsp;
            bus.d_d_source = dev_q[0].src;
        end
        bus.d_a_ready = roll(p_ardy);
        #1;
        cnt = exp_q.size();
        any = |bus.h_a_valid;
        chk("outstanding", 32'(outstanding), cnt);
        chk("unexp_idle", unexp, 0);
        if (owner < 0 && any && cnt < MO) begin
            for (int k = 1; k <= NH; k++) begin
                if (owner < 0 && bus.h_a_valid[(last_win + k) % NH])
                    owner = (last_win + k) % NH;
            end
        end
        exp_av = any && cnt < MO;
        chk("a_valid", bus.d_a_valid, exp_av);
        if (exp_av) begin
            chk("a_address", bus.d_a_address, hq[owner][0].addr);
            chk("a_data", bus.d_a_data, hq[owner][0].data);
            chk("a_source", bus.d_a_source, hq[owner][0].src);
        end
        for (int h = 0; h < NH; h++) begin
            if (bus.h_a_valid[h])
                chk("a_ready", bus.h_a_ready[h],
                    (exp_av && h == owner) ? bus.d_a_ready : 1'b0);
        end
        exp_dr = (cnt > 0) ? bus.h_d_ready[exp_q[0].host] : 1'b1;
        chk("d_ready", bus.d_d_ready, exp_dr);
        if (cnt > 0)
            chk("d_valid_head", bus.h_d_valid[exp_q[0].host], bus.d_d_valid);
        if (exp_av && bus.d_a_ready) begin
            r = hq[owner].pop_front();
            exp_q.push_back('{owner, r.addr + r.data, r.src});
            dev_q.push_back('{bus.d_a_address + bus.d_a_data, bus.d_a_source});
            last_win = owner;
            owner = -1;
        end
        if (bus.d_d_valid && bus.d_d_ready) begin
            if (dev_q.size() != 0) void'(dev_q.pop_front());
            d_hold = 1'b0;
        end
    endtask

    task automatic phase(input int n, input int pr, input int pa,
                         input int pd, input int pdr, input bit en);
        p_req  = pr;
        p_ardy = pa;
        p_dvld = pd;
        p_drdy = pdr;
        rsp_en = en;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int left;
        clear_inputs();
        clear_model();
        bus.h_a_valid = '1;
        bus.d_a_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_a_valid", bus.d_a_valid, 0);
        chk("rst_a_ready", 32'(bus.h_a_ready), 0);
        chk("rst_d_valid", 32'(bus.h_d_valid), 0);
        chk("rst_unexp", unexp, 0);
        clear_inputs();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        phase(40, 100, 100, 100, 100, 1'b1);
        phase(400, 60, 50, 50, 70, 1'b1);
        phase(20, 100, 100, 100, 100, 1'b0);
        phase(60, 100, 100, 100, 100, 1'b1);
        phase(300, 70, 20, 40, 50, 1'b1);
        phase(300, 50, 70, 80, 40, 1'b1);

        p_req = 0;
        left  = 300;
        while (left > 0 && (exp_q.size() != 0 || hq[0].size() != 0 ||
                            hq[1].size() != 0)) begin
            phase(1, 0, 100, 100, 100, 1'b1);
            left--;
        end
        if (left == 0) fail("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        clear_inputs();
        #1;

        @(negedge clk);
        bus.d_d_valid = 1'b1;
        #1;
        chk("unexp_d_ready", bus.d_d_ready, 1);
        chk("unexp_no_host", 32'(bus.h_d_valid), 0);
        chk("unexp_before", unexp, 0);
        @(negedge clk);
        bus.d_d_valid = 1'b0;
        #1;
        chk("unexp_pulse", unexp, 1);
        @(negedge clk);
        #1;
        chk("unexp_single", unexp, 0);

        phase(15, 100, 100, 100, 100, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        bus.h_a_valid = '1;
        bus.d_a_ready = 1'b1;
        bus.d_d_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outstanding", 32'(outstanding), 0);
        chk("mid_rst_a_valid", bus.d_a_valid, 0);
        chk("mid_rst_a_ready", 32'(bus.h_a_ready), 0);
        chk("mid_rst_d_valid", 32'(bus.h_d_valid), 0);
        clear_model();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        bus.d_d_valid = 1'b1;
        #1;
        chk("post_rst_no_host", 32'(bus.h_d_valid), 0);
        @(negedge clk);
        bus.d_d_valid = 1'b0;
        #1;
        chk("post_rst_unexp", unexp, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
